// File: rtl/serial_cfg_pkg.sv
// Shared types and helpers for the serial configuration master:
// FSM state encoding and a constant clog2 used for counter sizing.
package serial_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_cfg_master_if.sv
// Command/response handshake plus board serial pins of the configuration master.
// "master" is the view of the serial master itself, "slave" the view of its user.
interface serial_cfg_master_if #(
    parameter int pNUM_DEV = 4,
    parameter int pWORD_W  = 16,
    parameter int pDIV_W   = 8,
    parameter int pDEV_W   = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [pDEV_W-1:0]   cmd_dev;
    logic [pWORD_W-1:0]  cmd_data;
    logic [pDIV_W-1:0]   clk_div;
    logic                cpol;
    logic                rsp_valid;
    logic [pWORD_W-1:0]  rsp_data;
    logic                rsp_err;
    logic                busy;
    logic                sclk;
    logic                sdata;
    logic [pNUM_DEV-1:0] sen_n;
    logic                sdout;

    modport master (
        input  cmd_valid, cmd_dev, cmd_data, clk_div, cpol, sdout,
        output cmd_ready, busy, rsp_valid, rsp_data, rsp_err, sclk, sdata, sen_n
    );

    modport slave (
        output cmd_valid, cmd_dev, cmd_data, clk_div, cpol, sdout,
        input  cmd_ready, busy, rsp_valid, rsp_data, rsp_err, sclk, sdata, sen_n
    );
endinterface

// File: rtl/serial_cfg_tick.sv
// Half-period timer: loads on command accept, reloads from the latched divider
// and ticks for one cycle each time the count reaches zero.
module serial_cfg_tick #(
    parameter int pDIV_W = 8
) (
    input  logic              clk_usb,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [pDIV_W-1:0] i_start_val,
    input  logic [pDIV_W-1:0] i_reload_val,
    input  logic              i_run,
    output logic              o_tick
);
    logic [pDIV_W-1:0] r_cnt;

    // Counting down to zero avoids the extra bit an up-counter to 2^pDIV_W would need.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_start_val;
        end else if (i_run) begin
            if (r_cnt == '0) begin
                r_cnt <= i_reload_val;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/serial_cfg_master.sv
// Serial configuration master: one MSB-first word per command to one of pNUM_DEV
// targets, with runtime divider/polarity and simultaneous readback from sdout.
module serial_cfg_master
    import serial_cfg_pkg::*;
#(
    parameter int pNUM_DEV = 4,
    parameter int pWORD_W  = 16,
    parameter int pDIV_W   = 8,
    parameter int pDEV_W   = 2
) (
    input logic                 clk_usb,
    input logic                 reset_n,
    serial_cfg_master_if.master bus
);
    localparam int BIT_W = clog2(2 * pWORD_W) + 1;
    localparam logic [BIT_W-1:0] LAST_EDGE  = BIT_W'(2 * pWORD_W - 1);
    localparam logic [BIT_W-1:0] LAST_TRAIL = BIT_W'(2 * pWORD_W - 2);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_ready;
    logic                w_accept;
    logic                w_tick;
    logic                w_lead;
    logic                w_trail;
    logic                w_finish;
    logic                w_dev_err;
    logic [pNUM_DEV-1:0] w_sel_n;

    logic                r_dev_err;
    logic                r_cpol;
    logic                r_sclk;
    logic [pDIV_W-1:0]   r_div;
    logic [pWORD_W-1:0]  r_sout;
    logic [pWORD_W-1:0]  r_sin;
    logic [BIT_W-1:0]    r_bit;
    logic [pNUM_DEV-1:0] r_sen_n;
    logic                r_rsp_valid;
    logic [pWORD_W-1:0]  r_rsp_data;
    logic                r_rsp_err;

    assign w_ready   = (r_state == ST_IDLE);
    assign w_accept  = bus.cmd_valid && w_ready;
    assign w_dev_err = ({1'b0, bus.cmd_dev} >= (pDEV_W + 1)'(pNUM_DEV));

    // An out-of-range index matches no bit, so every enable stays released.
    for (genvar gi = 0; gi < pNUM_DEV; gi++) begin : g_sel
        assign w_sel_n[gi] = (bus.cmd_dev != pDEV_W'(gi));
    end

    serial_cfg_tick #(
        .pDIV_W (pDIV_W)
    ) u_tick (
        .clk_usb      (clk_usb),
        .reset_n      (reset_n),
        .i_start      (w_accept),
        .i_start_val  (bus.clk_div),
        .i_reload_val (r_div),
        .i_run        (!w_ready),
        .o_tick       (w_tick)
    );

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Even SHIFT half-periods sit at ~cpol; ticks at their end are trailing edges.
    always_comb begin
        w_state_next = r_state;
        w_lead       = 1'b0;
        w_trail      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_next = ST_SHIFT;
                    w_lead       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_bit == LAST_EDGE) begin
                        w_state_next = ST_HOLD;
                    end else if (!r_bit[0]) begin
                        w_trail = 1'b1;
                    end else begin
                        w_lead = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_next = ST_GAP;
                    w_finish     = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tick) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_dev_err   <= 1'b0;
            r_cpol      <= 1'b0;
            r_sclk      <= 1'b0;
            r_div       <= '0;
            r_sout      <= '0;
            r_sin       <= '0;
            r_bit       <= '0;
            r_sen_n     <= '1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_finish;
            if (w_accept) begin
                r_dev_err <= w_dev_err;
                r_cpol    <= bus.cpol;
                r_sclk    <= bus.cpol;
                r_div     <= bus.clk_div;
                r_sout    <= bus.cmd_data;
                r_sin     <= '0;
                r_bit     <= '0;
                r_sen_n   <= w_sel_n;
            end
            if (w_lead) begin
                r_sclk <= ~r_cpol;
                r_sin  <= {r_sin[pWORD_W-2:0], bus.sdout};
            end
            // The final trailing edge keeps the LSB on sdata through HOLD.
            if (w_trail) begin
                r_sclk <= r_cpol;
                if (r_bit != LAST_TRAIL) r_sout <= {r_sout[pWORD_W-2:0], 1'b0};
            end
            if ((r_state == ST_SHIFT) && w_tick) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_finish) begin
                r_sen_n    <= '1;
                r_rsp_err  <= r_dev_err;
                r_rsp_data <= r_dev_err ? '0 : r_sin;
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.busy      = ~w_ready;
    assign bus.sclk      = r_sclk;
    assign bus.sen_n     = r_sen_n;
    assign bus.sdata     = ((r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD))
                           ? r_sout[pWORD_W-1] : 1'b0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_serial_cfg_master.sv
// Self-checking bench for serial_cfg_master: table of commands with expected
// responses pushed to a scoreboard, plus back-to-back and mid-transfer reset cases.
module tb_serial_cfg_master;
    localparam int NDEV = 4;
    localparam int W    = 16;
    localparam int DW   = 8;
    localparam int DEVW = 3;

    logic clk_usb = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_usb = ~clk_usb;

    serial_cfg_master_if #(.pNUM_DEV(NDEV), .pWORD_W(W), .pDIV_W(DW), .pDEV_W(DEVW)) bus();

    serial_cfg_master #(
        .pNUM_DEV (NDEV),
        .pWORD_W  (W),
        .pDIV_W   (DW),
        .pDEV_W   (DEVW)
    ) dut (
        .clk_usb (clk_usb),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [DEVW-1:0] dev;
        logic [W-1:0]    data;
        logic [DW-1:0]   div;
        logic            cpol;
        logic [W-1:0]    slave;
        logic [W-1:0]    rsp;
        logic            err;
        int              busy;
        int              low;
        logic [NDEV-1:0] sen;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    logic abort  = 1'b0;

    function automatic vec_t mk(input logic [DEVW-1:0] dev, input logic [W-1:0] data,
                                input logic [DW-1:0] div, input logic cpol,
                                input logic [W-1:0] slave, input logic [W-1:0] rsp,
                                input logic err, input int busy, input int low,
                                input logic [NDEV-1:0] sen);
        vec_t v;
        v.dev = dev; v.data = data; v.div = div; v.cpol = cpol; v.slave = slave;
        v.rsp = rsp; v.err = err; v.busy = busy; v.low = low; v.sen = sen;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor, slave model and scoreboard consumer, all sampled on the falling clock edge.
    logic       busy_prev = 1'b0;
    logic       sclk_prev = 1'b0;
    int         busy_cnt  = 0;
    int         low_cnt   = 0;
    int         lead_cnt  = 0;
    int         run_len   = 0;
    int         rsp_cnt   = 0;
    logic       run_bad   = 1'b0;
    logic       sen_bad   = 1'b0;
    logic [W-1:0] cap      = '0;
    logic [W-1:0] slave_sh = '0;
    vec_t       cur;

    always @(negedge clk_usb) begin
        if (bus.busy) begin
            if (!busy_prev) begin
                chk("busy_has_cmd", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) cur = sb_q[0];
                busy_cnt = 0; low_cnt = 0; lead_cnt = 0; run_len = 0; rsp_cnt = 0;
                run_bad = 1'b0; sen_bad = 1'b0; cap = '0;
                slave_sh = cur.slave;
            end else if (bus.sclk != sclk_prev) begin
                if (run_len != int'(cur.div) + 1) run_bad = 1'b1;
                run_len = 0;
                if (bus.sclk != cur.cpol) begin
                    lead_cnt = lead_cnt + 1;
                    cap = {cap[W-2:0], bus.sdata};
                end else begin
                    slave_sh = {slave_sh[W-2:0], 1'b0};
                end
            end
            busy_cnt = busy_cnt + 1;
            run_len  = run_len + 1;
            if (bus.sen_n != '1) begin
                low_cnt = low_cnt + 1;
                if (bus.sen_n != cur.sen) sen_bad = 1'b1;
            end
        end else if (busy_prev) begin
            if (abort) begin
                chk("reset_no_rsp", 32'(rsp_cnt), 32'd0);
                abort = 1'b0;
            end else begin
                chk("busy_cycles", 32'(busy_cnt), 32'(cur.busy));
                chk("sen_low_cycles", 32'(low_cnt), 32'(cur.low));
                chk("sen_pattern", 32'(sen_bad), 32'd0);
                chk("sclk_lead_edges", 32'(lead_cnt), 32'(W));
                chk("sclk_half_period", 32'(run_bad), 32'd0);
                chk("rsp_pulses", 32'(rsp_cnt), 32'd1);
                chk("sclk_idle", 32'(bus.sclk), 32'(cur.cpol));
                chk("sdata_idle", 32'(bus.sdata), 32'd0);
                if (!cur.err) chk("sdata_word", 32'(cap), 32'(cur.data));
                $display("txn dev=%0d data=%h div=%0d cpol=%0d busy=%0d rsp=%h err=%0d",
                         cur.dev, cur.data, cur.div, cur.cpol, busy_cnt, bus.rsp_data, bus.rsp_err);
            end
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        if (bus.rsp_valid) begin
            rsp_cnt = rsp_cnt + 1;
            chk("rsp_expected", 32'(sb_q.size() != 0 && !abort), 32'd1);
            if (sb_q.size() != 0) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(sb_q[0].rsp));
                chk("rsp_err", 32'(bus.rsp_err), 32'(sb_q[0].err));
            end
        end
        bus.sdout = slave_sh[W-1];
        busy_prev = bus.busy;
        sclk_prev = bus.sclk;
    end

    task automatic drive(input vec_t v);
        bus.cmd_dev  = v.dev;
        bus.cmd_data = v.data;
        bus.clk_div  = v.div;
        bus.cpol     = v.cpol;
    endtask

    task automatic send(input vec_t v);
        int n;
        sb_q.push_back(v);
        @(negedge clk_usb);
        drive(v);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20000) begin
            @(negedge clk_usb);
            n = n + 1;
        end
        chk("accept_wait", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk_usb);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20000) begin
            @(negedge clk_usb);
            n = n + 1;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    initial begin
        int n;
        vec_t va;
        vec_t vb;

        vecs[0] = mk(3'd1, 16'hA5C3, 8'd0,   1'b0, 16'h1234, 16'h1234, 1'b0, 35,   34,   4'b1101);
        vecs[1] = mk(3'd2, 16'h0F0F, 8'd3,   1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 140,  136,  4'b1011);
        vecs[2] = mk(3'd5, 16'h1111, 8'd0,   1'b0, 16'hFFFF, 16'h0000, 1'b1, 35,   0,    4'b1111);
        vecs[3] = mk(3'd0, 16'hFFFF, 8'd1,   1'b0, 16'h8001, 16'h8001, 1'b0, 70,   68,   4'b1110);
        vecs[4] = mk(3'd3, 16'h0001, 8'd0,   1'b1, 16'h0000, 16'h0000, 1'b0, 35,   34,   4'b0111);
        vecs[5] = mk(3'd1, 16'h8000, 8'd255, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0, 8960, 8704, 4'b1101);
        vecs[6] = mk(3'd4, 16'h7E81, 8'd2,   1'b1, 16'hC3C3, 16'h0000, 1'b1, 105,  0,    4'b1111);

        bus.cmd_valid = 1'b0;
        bus.cmd_dev   = '0;
        bus.cmd_data  = '0;
        bus.clk_div   = '0;
        bus.cpol      = 1'b0;

        repeat (3) @(negedge clk_usb);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sen_n", 32'(bus.sen_n), 32'hF);
        chk("rst_sclk", 32'(bus.sclk), 32'd0);
        chk("rst_sdata", 32'(bus.sdata), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_usb);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            drain();
        end

        // Held cmd_valid across two commands; divider and fields change mid-transfer.
        va = mk(3'd2, 16'h3C5A, 8'd1, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 70, 68, 4'b1011);
        vb = mk(3'd0, 16'hC001, 8'd0, 1'b1, 16'h7777, 16'h7777, 1'b0, 35, 34, 4'b1110);
        sb_q.push_back(va);
        sb_q.push_back(vb);
        @(negedge clk_usb);
        drive(va);
        bus.cmd_valid = 1'b1;
        @(posedge clk_usb);
        #1;
        n = 0;
        while (n < 20000) begin
            @(negedge clk_usb);
            if (bus.cmd_ready) break;
            n = n + 1;
            if (n == 10) drive(vb);
        end
        chk("b2b_first_idle_accept", 32'(n), 32'd70);
        @(posedge clk_usb);
        #1 bus.cmd_valid = 1'b0;
        drain();

        // A request raised and dropped while busy must not be remembered.
        send(vecs[4]);
        repeat (5) @(negedge clk_usb);
        drive(vecs[0]);
        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge clk_usb);
        bus.cmd_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk_usb);
        chk("no_queue_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of SHIFT.
        send(mk(3'd2, 16'hABCD, 8'd0, 1'b0, 16'h1357, 16'h1357, 1'b0, 35, 34, 4'b1011));
        repeat (15) @(negedge clk_usb);
        chk("pre_reset_sen", 32'(bus.sen_n), 32'hB);
        #2;
        abort   = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sen_n", 32'(bus.sen_n), 32'hF);
        chk("mid_rst_sclk", 32'(bus.sclk), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (3) @(negedge clk_usb);
        reset_n = 1'b1;
        drain();
        send(vecs[0]);
        drain();

        repeat (5) @(negedge clk_usb);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
